// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    // Frame sequencer states; WAIT is only visited when the FIFO read data lags re by one cycle.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    // Level of the serial line between frames and during stop bits.
    localparam logic TX_IDLE = 1'b1;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module uart_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_done
);

    localparam int CNT_W = ceil_log2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit-period counter; restarts on clr so every new state gets a full bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_done = (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serialises them LSB-first as UART frames.
//
// state  | meaning
// IDLE   | line idle high, waiting for a non-empty FIFO
// FETCH  | single-cycle pop strobe; head word captured here when RD_LAT=0
// WAIT   | head word captured one cycle after the pop (RD_LAT=1)
// START  | start bit (line low)
// DATA   | data bits, LSB first, shift register moves once per bit
// PARITY | even parity of the captured word
// STOP   | STOP_BITS stop bits; chains straight into FETCH when more data is queued
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1,
    parameter int RD_LAT       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    output logic                 re,
    input  logic [DATA_SIZE-1:0] rddata,
    output logic                 tx,
    output logic                 busy
);

    localparam int BC_W = ceil_log2(DATA_SIZE + 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_SIZE - 1);
    localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

    state_t                 state_q;
    state_t                 state_nx;
    logic [DATA_SIZE-1:0]   shift_q;
    logic [DATA_SIZE-1:0]   shift_nx;
    logic                   parity_q;
    logic                   parity_nx;
    logic [BC_W-1:0]        bit_cnt_q;
    logic [BC_W-1:0]        bit_cnt_nx;
    logic                   tx_q;
    logic                   tx_nx;
    logic                   re_q;
    logic                   re_nx;
    logic                   busy_q;
    logic                   busy_nx;
    logic                   bit_done;
    logic                   baud_clr;

    // The bit timer restarts whenever the sequencer changes state.
    assign baud_clr = (state_nx != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_done (bit_done)
    );

    // Next-state, datapath updates and the registered-output values they imply.
    always_comb begin
        state_nx   = state_q;
        shift_nx   = shift_q;
        parity_nx  = parity_q;
        bit_cnt_nx = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (RD_LAT == 0) begin
                    shift_nx  = rddata;
                    parity_nx = ^rddata;
                    state_nx  = START;
                end else begin
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                shift_nx  = rddata;
                parity_nx = ^rddata;
                state_nx  = START;
            end
            START: begin
                if (bit_done) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_nx = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_nx = '0;
                        state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_nx = '0;
                        state_nx   = empty ? IDLE : FETCH;
                    end else begin
                        bit_cnt_nx = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            default: begin
                state_nx   = IDLE;
                bit_cnt_nx = '0;
            end
        endcase

        // Outputs are registered from the upcoming state so they change cleanly with it.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            PARITY:  tx_nx = parity_nx;
            default: tx_nx = TX_IDLE;
        endcase
        re_nx   = (state_nx == FETCH);
        busy_nx = (state_nx != IDLE);
    end

    // State, datapath and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            shift_q   <= shift_nx;
            parity_q  <= parity_nx;
            bit_cnt_q <= bit_cnt_nx;
            tx_q      <= tx_nx;
            re_q      <= re_nx;
            busy_q    <= busy_nx;
        end
    end

    assign tx   = tx_q;
    assign re   = re_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters fed by small depth-2 FIFO models:
// channel 0: RD_LAT=0, no parity, 1 stop bit; channel 1: RD_LAT=1, even parity, 2 stop bits.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst;
    logic [1:0] empty_w;
    logic [1:0] re_w;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
    logic [7:0] rd0;
    logic [7:0] rd1_q = 8'h00;

    logic [1:0] we = 2'b00;
    logic [7:0] wd [2];
    logic [7:0] mem [2][2];
    logic [1:0] fcnt [2] = '{2'd0, 2'd0};
    logic       rp [2] = '{1'b0, 1'b0};
    logic       wp [2] = '{1'b0, 1'b0};
    logic [1:0] pop;
    logic [1:0] psh;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int re_cnt [2] = '{0, 0};
    int re_bad = 0;
    int exp_re [2] = '{0, 0};
    int nstart [2] = '{0, 0};
    int nframes [2] = '{0, 0};
    int start_cyc [2][16];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];

    fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1), .RD_LAT(0)) u0 (
        .clk(clk), .rst(rst), .empty(empty_w[0]), .re(re_w[0]), .rddata(rd0),
        .tx(tx_w[0]), .busy(busy_w[0]));

    fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .empty(empty_w[1]), .re(re_w[1]), .rddata(rd1_q),
        .tx(tx_w[1]), .busy(busy_w[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign empty_w[0] = (fcnt[0] == 2'd0);
    assign empty_w[1] = (fcnt[1] == 2'd0);
    assign pop = re_w & ~empty_w;
    assign psh[0] = we[0] & (fcnt[0] != 2'd2);
    assign psh[1] = we[1] & (fcnt[1] != 2'd2);
    assign rd0 = mem[0][rp[0]];

    // Upstream FIFO models (not affected by the transmitter reset).
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (psh[c]) begin
                mem[c][wp[c]] <= wd[c];
                wp[c] <= ~wp[c];
            end
            if (pop[c]) rp[c] <= ~rp[c];
            fcnt[c] <= fcnt[c] + {1'b0, psh[c]} - {1'b0, pop[c]};
        end
        if (re_w[1]) rd1_q <= mem[1][rp[1]];
    end

    // Cycle counter and pop-strobe monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re_w[0]) re_cnt[0] <= re_cnt[0] + 1;
        if (re_w[1]) re_cnt[1] <= re_cnt[1] + 1;
        if ((re_w & empty_w) != 2'b00) re_bad <= re_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: each line bit held for 4 clocks.
    function automatic logic [47:0] frame_exp(input int c, input logic [7:0] w);
        logic [11:0] bits;
        logic [47:0] v;
        int nb;
        bits = '0;
        v = '0;
        bits[8:1] = w;
        if (c == 0) begin
            bits[9] = 1'b1;
            nb = 10;
        end else begin
            bits[9]  = ^w;
            bits[10] = 1'b1;
            bits[11] = 1'b1;
            nb = 12;
        end
        for (int i = 0; i < nb * 4; i++) v[i] = bits[i / 4];
        return v;
    endfunction

    // Line receiver: samples every clock, checks the whole frame against the scoreboard head.
    task automatic rx_run(input int c);
        logic [47:0] obs;
        logic [7:0]  w;
        int nb;
        bit aborted;
        nb = (c == 0) ? 10 : 12;
        forever begin
            @(negedge clk);
            if (rst && tx_w[c] === 1'b0) begin
                if (nstart[c] < 16) start_cyc[c][nstart[c]] = cyc;
                nstart[c]++;
                obs = '0;
                aborted = 0;
                for (int j = 1; j < nb * 4; j++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1;
                        break;
                    end
                    obs[j] = tx_w[c];
                end
                if (!aborted) begin
                    chk("sb_has_word", ((c == 0) ? sb0.size() : sb1.size()) != 0, 1'b1);
                    w = 8'h00;
                    if (c == 0 && sb0.size() != 0) w = sb0.pop_front();
                    if (c == 1 && sb1.size() != 0) w = sb1.pop_front();
                    chk((c == 0) ? "frame_ch0" : "frame_ch1", obs, frame_exp(c, w));
                    nframes[c]++;
                end
            end
        end
    endtask

    initial rx_run(0);
    initial rx_run(1);

    task automatic push(input int c, input logic [7:0] w);
        int n;
        n = 0;
        while (fcnt[c] == 2'd2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_space", fcnt[c] != 2'd2, 1'b1);
        we[c] = 1'b1;
        wd[c] = w;
        if (c == 0) sb0.push_back(w);
        else sb1.push_back(w);
        exp_re[c]++;
        @(negedge clk);
        we[c] = 1'b0;
    endtask

    task automatic wait_frames(input int c, input int n);
        int k;
        k = 0;
        while (nframes[c] < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", nframes[c] >= n, 1'b1);
    endtask

    task automatic wait_starts(input int c, input int n);
        int k;
        k = 0;
        while (nstart[c] < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", nstart[c] >= n, 1'b1);
    endtask

    task automatic wait_busy(input int c, input logic lvl, output int at);
        int k;
        k = 0;
        while (busy_w[c] !== lvl && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("busy_edge", busy_w[c], lvl);
        at = cyc;
    endtask

    task automatic wait_until_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int rise;
        int fall;
        int s;
        wd[0] = 8'h00;
        wd[1] = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset state, then idle with an empty FIFO.
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_w, 2'b11);
        chk("rst_re", re_w, 2'b00);
        chk("rst_busy", busy_w, 2'b00);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_no_re", re_cnt[0] + re_cnt[1], 0);
        chk("idle_busy", busy_w, 2'b00);
        chk("idle_tx", tx_w, 2'b11);

        // Single word, no parity.
        push(0, 8'hA5);
        wait_busy(0, 1'b1, rise);
        wait_busy(0, 1'b0, fall);
        wait_frames(0, 1);
        chk("pop_to_start0", start_cyc[0][0] - rise, 1);
        chk("busy_len0", fall - start_cyc[0][0], 40);
        chk("re_single", re_cnt[0], 1);

        // Back-to-back frames through a full FIFO.
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        push(0, 8'hC3);
        wait_frames(0, 5);
        for (int k = 2; k <= 4; k++) chk("b2b_period0", start_cyc[0][k] - start_cyc[0][k-1], 41);
        chk("re_b2b", re_cnt[0], 5);
        repeat (2) @(negedge clk);
        chk("empty_end", empty_w[0], 1'b1);

        // Parity and two stop bits, one-cycle read latency.
        push(1, 8'h07);
        wait_busy(1, 1'b1, rise);
        push(1, 8'h03);
        wait_frames(1, 2);
        wait_busy(1, 1'b0, fall);
        chk("pop_to_start1", start_cyc[1][0] - rise, 2);
        chk("b2b_period1", start_cyc[1][1] - start_cyc[1][0], 50);
        chk("busy_len1", fall - start_cyc[1][1], 48);

        // Word written while the previous frame is in its stop bits.
        push(0, 8'h11);
        wait_starts(0, 6);
        s = start_cyc[0][5];
        wait_until_cyc(s + 37);
        push(0, 8'h22);
        wait_frames(0, 7);
        chk("stop_chain0", start_cyc[0][6] - start_cyc[0][5], 41);

        push(1, 8'h33);
        wait_starts(1, 3);
        s = start_cyc[1][2];
        wait_until_cyc(s + 42);
        push(1, 8'h44);
        wait_frames(1, 4);
        chk("stop_chain1", start_cyc[1][3] - start_cyc[1][2], 50);

        // Reset during data bit 3 of 8'h5A; the aborted word is dropped.
        push(0, 8'h5A);
        push(0, 8'h81);
        wait_starts(0, 8);
        s = start_cyc[0][7];
        wait_until_cyc(s + 17);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", tx_w, 2'b11);
        chk("midrst_busy", busy_w, 2'b00);
        chk("midrst_re", re_w, 2'b00);
        void'(sb0.pop_front());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_frames(0, 8);
        repeat (4) @(negedge clk);

        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        chk("re_total0", re_cnt[0], exp_re[0]);
        chk("re_total1", re_cnt[1], exp_re[1]);
        chk("re_when_empty", re_bad, 0);
        chk("final_empty", empty_w, 2'b11);
        chk("final_busy", busy_w, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
